wb_uart_tx: RTL and testbench



---
 rtl/wb_uart_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx.sv
// wb_uart_tx
// Wishbone-slave UART transmitter. Firmware pushes bytes into an 8-entry
// FIFO and programs a baud divisor. A TX state machine drains the FIFO onto
// ser_tx as 8N1 frames, with each bit lasting DIV+1 clock cycles.
//
// Register map (byte offset from the base address, 16-byte window):
//   0x0 DATA   : write pushes i_wb_data[7:0]; reads 0
//   0x4 STATUS : read  {count[11:8], overflow[3], busy[2], empty[1], full[0]}
//                write 1 to bit3 clears the sticky overflow flag
//   0x8 DIV    : read/write bits[15:0]
//   0xC        : reads 0, writes ignored
//
// Ports:
//   clk, reset       : single clock, synchronous active-high reset
//   i_wb_cyc/stb/we  : Wishbone cycle, strobe, write enable
//   i_wb_addr        : byte address, [3:2] selects the register
//   i_wb_data        : write data
//   o_wb_ack         : one-cycle acknowledge, one cycle after the request
//   o_wb_data        : read data, nonzero only while o_wb_ack is high
//   ser_tx           : serial line, idles high
//   tx_busy          : high while a frame is on the line
//   o_dbg_state      : current TX state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: a request is cyc & stb & sel & !o_wb_ack. It is acknowledged
// on the following cycle for exactly one cycle; all register side effects
// happen at the edge that raises o_wb_ack.
module wb_uart_tx #(
  parameter logic [31:0] address   = 32'h0300_0100,
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        ser_tx,
  output logic        tx_busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Bus-side registers
  logic        r_ack;
  logic [31:0] r_rdata;
  logic [15:0] r_div;
  logic        r_ovf;

  // FIFO
  logic [7:0]  r_mem [0:7];
  logic [2:0]  r_wr_ptr;
  logic [2:0]  r_rd_ptr;
  logic [3:0]  r_count;

  // Transmitter
  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic [15:0] r_bit_cnt;
  logic [15:0] r_div_lat;

  logic        w_sel;
  logic        w_req;
  logic [1:0]  w_reg;
  logic        w_full;
  logic        w_empty;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_busy;
  logic        w_cnt_zero;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_sel      = (i_wb_addr[31:4] == address[31:4]);
  assign w_req      = i_wb_cyc & i_wb_stb & w_sel & ~r_ack;
  assign w_reg      = i_wb_addr[3:2];
  assign w_full     = (r_count == 4'd8);
  assign w_empty    = (r_count == 4'd0);
  assign w_push_req = w_req & i_wb_we & (w_reg == 2'd0);
  // Full is judged on the pre-edge count, so a push into a full FIFO is
  // dropped even when the transmitter pops on the same edge.
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_busy     = (r_state != S_IDLE);
  assign w_cnt_zero = (r_bit_cnt == 16'd0);
  assign w_unused   = ^{i_wb_data[31:16], i_wb_addr[1:0]};

  // Read mux; STATUS shows the FIFO as it stands before this edge.
  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      2'd1:    w_rdata = {20'd0, r_count, 4'd0, r_ovf, w_busy, w_empty, w_full};
      2'd2:    w_rdata = {16'd0, r_div};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
      r_div   <= DIV_RESET;
      r_ovf   <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= (w_req & ~i_wb_we) ? w_rdata : 32'd0;
      if (w_req & i_wb_we & (w_reg == 2'd2)) begin
        r_div <= i_wb_data[15:0];
      end
      if (w_push_req & w_full) begin
        r_ovf <= 1'b1;
      end else if (w_req & i_wb_we & (w_reg == 2'd1) & i_wb_data[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_wb_ack  = r_ack;
  assign o_wb_data = r_rdata;

  // FIFO storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wb_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
      r_count <= r_count + {3'd0, w_push} - {3'd0, w_pop};
    end
  end

  // TX FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // TX FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (~w_empty) w_state_next = S_START;
      S_START: if (w_cnt_zero) w_state_next = S_DATA;
      S_DATA:  if (w_cnt_zero && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      S_STOP:  if (w_cnt_zero) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // TX datapath: the divisor is latched at pop time so a DIV write during
  // a frame only affects the next one. The bit counter runs DIV..0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= 8'd0;
      r_bit_idx <= 3'd0;
      r_bit_cnt <= 16'd0;
      r_div_lat <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (~w_empty) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_div_lat <= r_div;
            r_bit_cnt <= r_div;
          end
        end
        S_START: begin
          if (w_cnt_zero) begin
            r_bit_idx <= 3'd0;
            r_bit_cnt <= r_div_lat;
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_cnt_zero) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            r_bit_cnt <= r_div_lat;
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (~w_cnt_zero) begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // TX FSM: outputs
  always_comb begin
    ser_tx  = 1'b1;
    tx_busy = 1'b1;
    case (r_state)
      S_IDLE:  begin ser_tx = 1'b1;       tx_busy = 1'b0; end
      S_START: begin ser_tx = 1'b0;       tx_busy = 1'b1; end
      S_DATA:  begin ser_tx = r_shift[0]; tx_busy = 1'b1; end
      S_STOP:  begin ser_tx = 1'b1;       tx_busy = 1'b1; end
      default: begin ser_tx = 1'b1;       tx_busy = 1'b0; end
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Testbench for wb_uart_tx. Inputs are driven on the falling edge and
// outputs sampled on the falling edge, half a cycle after the active edge.
module tb_wb_uart_tx;

  localparam logic [31:0] BASE  = 32'h0300_0100;
  localparam logic [31:0] A_DAT = BASE + 32'h0;
  localparam logic [31:0] A_STA = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RES = BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
  logic        ser_tx;
  logic        tx_busy;
  logic [1:0]  o_dbg_state;

  int n_checks;
  int n_fail;

  wb_uart_tx #(.address(BASE), .DIV_RESET(16'd103)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .o_wb_ack   (o_wb_ack),
    .o_wb_data  (o_wb_data),
    .ser_tx     (ser_tx),
    .tx_busy    (tx_busy),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic bus_idle();
    i_wb_cyc  = 1'b0;
    i_wb_stb  = 1'b0;
    i_wb_we   = 1'b0;
    i_wb_addr = 32'd0;
    i_wb_data = 32'd0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input string name);
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    @(negedge clk);
    chk({name, " ack"}, {31'd0, o_wb_ack}, 32'd1);
    bus_idle();
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, input string name);
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a; i_wb_data = 32'd0;
    @(negedge clk);
    chk({name, " ack"}, {31'd0, o_wb_ack}, 32'd1);
    d = o_wb_data;
    bus_idle();
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    wb_read(a, d, name);
    chk(name, d, exp);
  endtask

  // Checks one full 8N1 frame starting at the next falling edge.
  task automatic check_frame(input logic [7:0] b, input int div, input string name);
    int errs;
    int first;
    int bitn;
    logic exp;
    errs = 0;
    first = -1;
    for (int i = 0; i < 10 * (div + 1); i++) begin
      @(negedge clk);
      bitn = i / (div + 1);
      if (bitn == 0)      exp = 1'b0;
      else if (bitn == 9) exp = 1'b1;
      else                exp = b[bitn - 1];
      if ((ser_tx !== exp) || (tx_busy !== 1'b1)) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first at cycle %0d (ser_tx/busy wrong) expected byte 0x%02h div %0d",
               name, errs, first, b, div);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk(name, {30'd0, ser_tx, tx_busy}, 32'h2);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int acks;
    logic [31:0] d;
    n_checks = 0;
    n_fail   = 0;
    bus_idle();

    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ser_tx", {31'd0, ser_tx}, 32'd1);
    chk("reset busy", {31'd0, tx_busy}, 32'd0);
    chk("reset ack", {31'd0, o_wb_ack}, 32'd0);
    chk("reset rdata", o_wb_data, 32'd0);
    chk("reset state", {30'd0, o_dbg_state}, 32'd0);
    reset = 1'b0;

    // Register access table
    vecs[0]  = '{A_STA, 1'b0, 32'h0,         32'h0000_0002};
    vecs[1]  = '{A_DIV, 1'b0, 32'h0,         32'h0000_0067};
    vecs[2]  = '{A_DAT, 1'b0, 32'h0,         32'h0000_0000};
    vecs[3]  = '{A_RES, 1'b0, 32'h0,         32'h0000_0000};
    vecs[4]  = '{A_DIV, 1'b1, 32'hABCD_1234, 32'h0};
    vecs[5]  = '{A_DIV, 1'b0, 32'h0,         32'h0000_1234};
    vecs[6]  = '{A_RES, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{A_RES, 1'b0, 32'h0,         32'h0000_0000};
    vecs[8]  = '{A_STA, 1'b1, 32'hFFFF_FFF7, 32'h0};
    vecs[9]  = '{A_STA, 1'b0, 32'h0,         32'h0000_0002};
    vecs[10] = '{A_DIV, 1'b0, 32'h0,         32'h0000_1234};
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) begin
        wb_write(vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
      end else begin
        rd_chk(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end
    end
    @(negedge clk);
    chk("rdata zero outside ack", o_wb_data, 32'd0);
    chk("ser_tx idle after regs", {31'd0, ser_tx}, 32'd1);

    // Single frame, DIV=3
    wb_write(A_DIV, 32'd3, "div3");
    wb_write(A_DAT, 32'h55, "push55");
    check_frame(8'h55, 3, "frame 0x55");
    check_idle("idle after 0x55");

    // Back-to-back frames, DIV=0
    wb_write(A_DIV, 32'd0, "div0");
    wb_write(A_DAT, 32'h01, "push01");
    fork
      begin
        check_frame(8'h01, 0, "frame 0x01");
        check_idle("gap 1");
        check_frame(8'h80, 0, "frame 0x80");
        check_idle("gap 2");
        check_frame(8'hFF, 0, "frame 0xFF");
        check_idle("gap 3");
      end
      begin
        wb_write(A_DAT, 32'h80, "push80");
        wb_write(A_DAT, 32'hFF, "pushFF");
        rd_chk(A_STA, 32'h0000_0204, "status two queued");
      end
    join
    rd_chk(A_STA, 32'h0000_0002, "status drained");

    // DIV change mid-frame
    wb_write(A_DIV, 32'd1, "div1");
    wb_write(A_DAT, 32'h3C, "push3C");
    fork
      begin
        check_frame(8'h3C, 1, "frame old div");
        check_idle("gap div");
        check_frame(8'hC3, 7, "frame new div");
        check_idle("idle after div");
      end
      begin
        wb_write(A_DIV, 32'd7, "div7 midframe");
        wb_write(A_DAT, 32'hC3, "pushC3");
      end
    join

    // Handshake: stb held through the ack cycle gives one ack, one push
    wb_write(A_DIV, 32'h0000_FFFF, "divFFFF");
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = A_DAT; i_wb_data = 32'hA5;
    acks = 0;
    @(negedge clk); acks += int'(o_wb_ack);
    @(negedge clk); acks += int'(o_wb_ack);
    bus_idle();
    @(negedge clk); acks += int'(o_wb_ack);
    chk("held stb ack count", acks, 32'd1);
    rd_chk(A_STA, 32'h0000_0006, "status one push");

    // Unselected address: no ack
    @(negedge clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = 32'h0300_0200; i_wb_data = 32'h11;
    acks = 0;
    @(negedge clk); acks += int'(o_wb_ack);
    @(negedge clk); acks += int'(o_wb_ack);
    bus_idle();
    @(negedge clk); acks += int'(o_wb_ack);
    chk("unselected ack count", acks, 32'd0);

    // Overflow: 8 more pushes fill the FIFO, the next one is dropped
    for (int i = 0; i < 8; i++) begin
      wb_write(A_DAT, 32'(i), $sformatf("fill%0d", i));
    end
    rd_chk(A_STA, 32'h0000_0805, "status full");
    wb_write(A_DAT, 32'hEE, "push when full");
    rd_chk(A_STA, 32'h0000_080D, "status overflow");
    wb_write(A_STA, 32'h8, "clear ovf");
    rd_chk(A_STA, 32'h0000_0805, "status ovf cleared");
    chk("ser_tx in start", {31'd0, ser_tx}, 32'd0);
    chk("state in start", {30'd0, o_dbg_state}, 32'd1);

    // Reset mid-frame
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset midframe ser_tx", {31'd0, ser_tx}, 32'd1);
    chk("reset midframe busy", {31'd0, tx_busy}, 32'd0);
    reset = 1'b0;
    rd_chk(A_STA, 32'h0000_0002, "status after reset");
    rd_chk(A_DIV, 32'h0000_0067, "div after reset");
    check_idle("idle after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
